// File: rtl/alu_pkg.sv
// Shared ALU types: serial-adder FSM states and nibble geometry.
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } serial_add_state_t;

   localparam int NIB_BITS = 4;

   function automatic int nib_count(input int width);
      return width / NIB_BITS;
   endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Request/response bundle for the nibble-serial adder.
interface nibble_serial_add_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic             op_sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;
   logic             busy;

   modport master (
      output in_valid, op_sub, a, b, out_ready,
      input  in_ready, out_valid, result, carry_out, overflow, busy
   );

   modport slave (
      input  in_valid, op_sub, a, b, out_ready,
      output in_ready, out_valid, result, carry_out, overflow, busy
   );
endinterface

// File: rtl/FullAdder_4.sv
// 4-bit ripple-carry adder slice.
module FullAdder_4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   logic c;

   always_comb begin
      sum = '0;
      c   = cin;
      for (int i = 0; i < 4; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add/subtract: one 4-bit slice reused NIB cycles, LSB nibble first,
// valid/ready on both the request and the result side.
module nibble_serial_add_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic                      clk,
   input logic                      rst_n,
   nibble_serial_add_ctrl_if.slave  bus
);
   localparam int NIB   = nib_count(WIDTH);
   localparam int CNT_W = $clog2(NIB);
   localparam int MSB   = WIDTH - 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

   serial_add_state_t state;
   logic [CNT_W-1:0]  cnt;
   logic              carry;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [WIDTH-1:0]  result_q;
   logic              carry_out_q;
   logic              overflow_q;
   logic              in_ready_q;
   logic              out_valid_q;
   logic              busy_q;

   logic [CNT_W+1:0]  nib_base;
   logic [3:0]        slice_sum;
   logic              slice_cout;

   assign nib_base = {cnt, 2'b00};

   FullAdder_4 u_slice (
      .a    (a_q[nib_base +: 4]),
      .b    (b_q[nib_base +: 4]),
      .cin  (carry),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // Operands are pure data: loaded on acceptance only, never reset.
   always_ff @(posedge clk) begin
      if (state == IDLE && bus.in_valid) begin
         a_q <= bus.a;
         b_q <= bus.b ^ {WIDTH{bus.op_sub}};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         carry       <= 1'b0;
         result_q    <= '0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  cnt        <= '0;
                  carry      <= bus.op_sub;
                  state      <= RUN;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            RUN: begin
               result_q[nib_base +: 4] <= slice_sum;
               carry                   <= slice_cout;
               if (cnt == CNT_LAST) begin
                  cnt         <= '0;
                  state       <= DONE;
                  out_valid_q <= 1'b1;
                  carry_out_q <= slice_cout;
                  // slice_sum[3] is the result MSB being written on this edge.
                  overflow_q  <= (a_q[MSB] == b_q[MSB]) && (slice_sum[3] != a_q[MSB]);
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.result    = result_q;
   assign bus.carry_out = carry_out_q;
   assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl at WIDTH=32.
module tb_nibble_serial_add_ctrl;
   localparam int W   = 32;
   localparam int NIB = W / 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   nibble_serial_add_ctrl_if #(.WIDTH(W)) bus ();

   nibble_serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [W-1:0] res;
      logic         co;
      logic         ov;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;
   int   acc_edge = 0;
   int   prev_acc = -1;
   logic prev_ov  = 1'b0;
   logic b2b      = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic sub);
      exp_t         e;
      logic [W-1:0] beff;
      logic [W:0]   s;
      beff = sub ? ~mb : mb;
      s    = {1'b0, ma} + {1'b0, beff} + {{W{1'b0}}, sub};
      e.res = s[W-1:0];
      e.co  = s[W];
      e.ov  = (ma[W-1] == beff[W-1]) && (s[W-1] != ma[W-1]);
      return e;
   endfunction

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            sbq.delete();
            prev_ov  = 1'b0;
            prev_acc = -1;
         end else begin
            if (bus.in_valid && bus.in_ready) begin
               sbq.push_back(model(bus.a, bus.b, bus.op_sub));
               acc_edge = cyc + 1;
               if (b2b && prev_acc >= 0) chk("spacing", 64'(acc_edge - prev_acc), 64'(NIB + 2));
               prev_acc = b2b ? acc_edge : -1;
            end
            if (bus.out_valid && !prev_ov) chk("latency", 64'(cyc - acc_edge), 64'(NIB));
            if (bus.out_valid && bus.out_ready) begin
               if (sbq.size() == 0) begin
                  chk("unexpected_out", 64'd1, 64'd0);
               end else begin
                  e = sbq.pop_front();
                  chk("result", 64'(bus.result), 64'(e.res));
                  chk("carry_out", 64'(bus.carry_out), 64'(e.co));
                  chk("overflow", 64'(bus.overflow), 64'(e.ov));
               end
            end
            prev_ov = bus.out_valid;
         end
      end
   endtask

   task automatic do_req(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rop);
      int n;
      n = 0;
      @(posedge clk);
      #1;
      bus.a        = ra;
      bus.b        = rb;
      bus.op_sub   = rop;
      bus.in_valid = 1'b1;
      @(negedge clk);
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("req_timeout", 64'd1, 64'd0);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((sbq.size() != 0 || !bus.in_ready) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("drain_timeout", 64'd1, 64'd0);
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_in_ready"}, 64'(bus.in_ready), 64'd1);
      chk({pfx, "_out_valid"}, 64'(bus.out_valid), 64'd0);
      chk({pfx, "_busy"}, 64'(bus.busy), 64'd0);
      chk({pfx, "_result"}, 64'(bus.result), 64'd0);
      chk({pfx, "_carry_out"}, 64'(bus.carry_out), 64'd0);
      chk({pfx, "_overflow"}, 64'(bus.overflow), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   logic [W-1:0] ta [6];
   logic [W-1:0] tb [6];
   logic         top[6];
   int           ovc;
   int           n;

   initial begin
      ta  = '{32'h0000_000F, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0005, 32'h1234_5678};
      tb  = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0007, 32'h1234_5678};
      top = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

      bus.in_valid  = 1'b0;
      bus.op_sub    = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;
      rst_n         = 1'b0;

      fork
         monitor();
      join_none

      #12;
      chk_reset_vals("rst");
      @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("release_idle_busy", 64'(bus.busy), 64'd0);
      chk("release_idle_ready", 64'(bus.in_ready), 64'd1);

      for (int i = 0; i < 6; i++) begin
         do_req(ta[i], tb[i], top[i]);
         wait_drain();
      end
      for (int i = 0; i < 6; i++) begin
         do_req($urandom, $urandom, 1'($urandom_range(0, 1)));
         wait_drain();
      end

      // Backpressure with operand churn during RUN and DONE
      bus.out_ready = 1'b0;
      do_req(32'h1234_5678, 32'h0FED_CBA9, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      bus.a        = $urandom;
      bus.b        = $urandom;
      bus.op_sub   = 1'b1;
      bus.in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.out_valid && n < 50) begin
         chk("bp_run_in_ready", 64'(bus.in_ready), 64'd0);
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("bp_timeout", 64'd1, 64'd0);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk("bp_hold_result", 64'(bus.result), 64'(32'h1234_5678 + 32'h0FED_CBA9));
         chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
         chk("bp_hold_in_ready", 64'(bus.in_ready), 64'd0);
      end
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_back_idle", 64'(bus.in_ready), 64'd1);
      chk("bp_back_busy", 64'(bus.busy), 64'd0);
      wait_drain();

      // Reset asserted with cnt=3
      do_req(32'hAAAA_5555, 32'h1111_2222, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_reset_vals("abort");
      @(posedge clk);
      #3 rst_n = 1'b1;
      ovc = 0;
      repeat (2 * NIB) begin
         @(negedge clk);
         if (bus.out_valid) ovc++;
      end
      chk("abort_no_out_valid", 64'(ovc), 64'd0);
      do_req(32'd5, 32'd3, 1'b1);
      wait_drain();
      chk("after_abort_result", 64'(bus.result), 64'd2);
      chk("after_abort_carry", 64'(bus.carry_out), 64'd1);

      // Back-to-back with in_valid held high
      b2b = 1'b1;
      @(posedge clk);
      #1;
      bus.a        = 32'hDEAD_BEEF;
      bus.b        = 32'h0123_4567;
      bus.op_sub   = 1'b0;
      bus.in_valid = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      bus.a      = 32'h0000_0010;
      bus.b      = 32'h0000_0020;
      bus.op_sub = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("b2b_timeout", 64'd1, 64'd0);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      wait_drain();
      chk("b2b_last_result", 64'(bus.result), 64'hFFFF_FFF0);
      b2b = 1'b0;

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width; SHALL be a multiple of 4 and at least 8.
REQ-002 Derived constant NIB = WIDTH/4: number of compute cycles.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op_sub  input  1  0 = a+b, 1 = a-b.
REQ-008 a  input  WIDTH  first operand.
REQ-009 b  input  WIDTH  second operand.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-013 carry_out  output  1  carry out of bit WIDTH-1 (for subtract: 1 = no borrow).
REQ-014 overflow  output  1  two's-complement signed overflow.
REQ-015 busy  output  1  high in RUN or DONE.

Function
REQ-016 FSM states SHALL be IDLE, RUN and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 IDLE with in_valid=1: on that edge, latch a, b XOR {WIDTH{op_sub}}, and carry = op_sub; clear the nibble counter to 0; go to RUN.
REQ-019 RUN, each cycle: feed nibble[cnt] of the latched a and b_eff plus the carry register into one 4-bit adder slice; write the 4-bit sum into result nibble[cnt]; store the slice carry-out in the carry register; increment cnt.
REQ-020 RUN with cnt=NIB-1: after that edge, go to DONE; carry_out = final slice carry; overflow = (a[MSB]==b_eff[MSB]) && (result[MSB]!=a[MSB]).
REQ-021 Latency: out_valid SHALL rise exactly NIB rising edges after the accepting edge (8 for WIDTH=32).
REQ-022 DONE: result, carry_out and overflow SHALL hold stable while out_ready=0.
REQ-023 DONE with out_ready=1: transfer completes on that edge; go to IDLE. A new request is accepted no earlier than the following cycle (minimum spacing NIB+2 cycles).
REQ-024 Inputs a, b, op_sub and in_valid SHALL be ignored outside IDLE; changes during RUN SHALL NOT affect the result.
REQ-025 The counter SHALL be clog2(NIB) bits wide and SHALL wrap only via the transition to DONE; it never exceeds NIB-1.
REQ-026 Carry chaining SHALL be strictly LSB nibble first.
REQ-027 result SHALL keep its last value in IDLE until overwritten by the next RUN.

Reset
REQ-028 rst_n=0 SHALL force, asynchronously, state=IDLE, cnt=0, carry=0, result=0, carry_out=0, overflow=0, out_valid=0, busy=0 and in_ready=1 (in_ready=1 once released).
REQ-029 Reset asserted during RUN or DONE SHALL abort the operation; no out_valid SHALL follow for the aborted request.
REQ-030 Release of reset SHALL take effect on the next rising edge, with no spurious acceptance on that edge unless in_valid=1.

Structure
REQ-031 The state enum (IDLE/RUN/DONE) SHALL reside in the shared package alu_pkg as type serial_add_state_t.
REQ-032 The block SHALL instantiate exactly one existing 4-bit ripple adder, FullAdder_4, as its datapath slice; no other adder logic is permitted.
REQ-033 Operand and result registers, the counter and the FSM SHALL live in this module.

Verification
REQ-034 Add: a=0x0000_000F, b=0x0000_0001, op_sub=0 -> after 8 edges: out_valid=1, result=0x0000_0010, carry_out=0, overflow=0.
REQ-035 Wrap: a=0xFFFF_FFFF, b=0x0000_0001, add -> result=0x0000_0000, carry_out=1, overflow=0.
REQ-036 Signed overflow: a=0x7FFF_FFFF, b=0x0000_0001, add -> result=0x8000_0000, overflow=1; subtract a=0x8000_0000, b=1 -> result=0x7FFF_FFFF, overflow=1, carry_out=1.
REQ-037 Backpressure: hold out_ready=0 for 5 cycles in DONE and change a/b during RUN -> result stable and unaffected by the changes; in_ready=0 throughout; IDLE follows the out_ready edge.
REQ-038 Reset mid-operation: assert rst_n=0 at RUN cnt=3 -> outputs immediately match the REQ-028 values; no out_valid follows; the next request, 5-3, gives result=2 and carry_out=1.
REQ-039 Back-to-back: two requests with in_valid held high and out_ready=1 -> acceptances are exactly NIB+2 cycles apart, and both results are correct.
